// File: rtl/response_tx_queue_pkg.sv
// Shared definitions for the response transmit queue: FSM state encoding and
// the default queue depth.
package response_tx_queue_pkg;

  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with a combinational head read. Pointers wrap naturally
// because DEPTH is a power of two.
module byte_fifo
  import response_tx_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full queue still accepts a byte when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: all sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale bytes are unreachable once the
  // pointers and count are cleared, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clock) begin
    if (reset && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/response_tx_queue.sv
// Queues response bytes and hands them one at a time to a UART transmitter
// using a start/done handshake; flags any byte dropped on a full queue.
module response_tx_queue
  import response_tx_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   response_ready,
  input  logic [7:0]             response,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   queue_empty,
  output logic                   overflow
);

  tx_state_t  state;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (response_ready),
    .pop   (pop),
    .din   (response),
    .dout  (fifo_dout),
    .count (queue_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign queue_empty = fifo_empty;
  assign pop         = (state == IDLE) && !fifo_empty && !tx_busy;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (response_ready && fifo_full && !pop) overflow <= 1'b1;

      case (state)
        IDLE: begin
          tx_start <= 1'b0;
          if (pop) begin
            state    <= START;
            tx_start <= 1'b1;
            tx_data  <= fifo_dout;
          end
        end
        START: begin
          state    <= WAIT_DONE;
          tx_start <= 1'b0;
        end
        WAIT_DONE: begin
          tx_start <= 1'b0;
          if (tx_done) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          tx_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_response_tx_queue.sv
// Directed bench for response_tx_queue: expected bytes go into a scoreboard
// queue and a monitor checks every tx_start against it.
module tb_response_tx_queue;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       response_ready = 1'b0;
  logic [7:0] response = 8'h00;
  logic       tx_busy;
  logic       tx_done = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [$clog2(DEPTH):0] queue_count;
  logic       queue_empty;
  logic       overflow;

  logic busy_force = 1'b0;
  logic model_busy = 1'b0;
  bit   resp_en    = 1'b1;
  int   done_delay = 3;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  assign tx_busy = busy_force | model_busy;

  always #5 clock = ~clock;

  response_tx_queue #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .response_ready (response_ready),
    .response       (response),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .queue_count    (queue_count),
    .queue_empty    (queue_empty),
    .overflow       (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every frame start must carry the oldest outstanding expected byte.
  always @(negedge clock) begin
    if (tx_start) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_tx_start: got data %0h, expected no frame", tx_data);
      end else begin
        check("tx_data", tx_data, exp_q.pop_front());
      end
    end
  end

  // UART model: answers each tx_start with tx_done done_delay cycles later.
  initial begin
    forever begin
      @(negedge clock);
      if (tx_start && resp_en) begin
        model_busy = 1'b1;
        repeat (done_delay) @(negedge clock);
        model_busy = 1'b0;
        tx_done    = 1'b1;
        @(negedge clock);
        tx_done    = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic push(input logic [7:0] b, input bit sent);
    response_ready = 1'b1;
    response       = b;
    if (sent) exp_q.push_back(b);
    @(negedge clock);
    response_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check({name, "_drain_left"}, exp_q.size(), 0);
    repeat (done_delay + 4) @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    apply_reset();
    check("rst_count", queue_count, 0);
    check("rst_empty", queue_empty, 1);
    check("rst_overflow", overflow, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);

    // Single byte and push-to-start latency
    push(8'hA5, 1);
    check("lat_c1_tx_start", tx_start, 0);
    check("lat_c1_count", queue_count, 1);
    @(negedge clock);
    check("lat_c2_tx_start", tx_start, 1);
    check("lat_c2_tx_data", tx_data, 8'hA5);
    check("lat_c2_count", queue_count, 0);
    drain("single");
    check("single_empty", queue_empty, 1);
    check("single_tx_start_low", tx_start, 0);

    // Code/data pair keeps order
    push(8'h01, 1);
    push(8'h3C, 1);
    drain("pair");
    check("pair_overflow", overflow, 0);

    // Overflow while the transmitter is busy
    busy_force = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i), i < 4);
    check("ovf_count", queue_count, 4);
    check("ovf_flag", overflow, 1);
    busy_force = 1'b0;
    drain("ovf");
    check("ovf_sticky", overflow, 1);
    apply_reset();
    check("ovf_cleared", overflow, 0);

    // Push into a full queue in the same cycle as a pop
    busy_force = 1'b1;
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i), 1);
    check("full_count", queue_count, 4);
    busy_force = 1'b0;
    push(8'hEE, 1);
    check("full_pop_count", queue_count, 4);
    check("full_pop_overflow", overflow, 0);
    drain("full_pop");
    check("full_pop_overflow_end", overflow, 0);

    // Reset in WAIT_DONE with bytes still queued
    resp_en    = 1'b0;
    busy_force = 1'b1;
    push(8'h30, 1);
    for (int i = 1; i < 4; i++) push(8'h30 + 8'(i), 0);
    busy_force = 1'b0;
    repeat (2) @(negedge clock);
    check("midrst_pre_count", queue_count, 3);
    reset          = 1'b0;
    response_ready = 1'b1;
    response       = 8'h99;
    @(negedge clock);
    reset          = 1'b1;
    response_ready = 1'b0;
    check("midrst_count", queue_count, 0);
    check("midrst_empty", queue_empty, 1);
    check("midrst_tx_start", tx_start, 0);
    check("midrst_tx_data", tx_data, 8'h00);
    tx_done = 1'b1;
    @(negedge clock);
    tx_done = 1'b0;
    repeat (3) @(negedge clock);
    check("stray_done_count", queue_count, 0);
    check("stray_done_tx_start", tx_start, 0);
    resp_en = 1'b1;
    push(8'h77, 1);
    drain("after_rst");

    // Stream ten bytes through the wrapping pointers
    for (int i = 0; i < 10; i++) begin
      int n = 0;
      while (queue_count == (DEPTH) && n < 200) begin
        @(negedge clock);
        n++;
      end
      push(8'(i), 1);
    end
    drain("wrap");
    check("wrap_overflow", overflow, 0);
    check("final_empty", queue_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/response_tx_queue.md
RESPONSE_TX_QUEUE -- requirements
Module: response_tx_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of byte entries in the queue; SHALL be a power of two, 2 to 16.
REQ-002 Port: clock  input  1  single system clock; all logic on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset.
REQ-004 Port: response_ready  input  1  one-cycle push strobe from ResponseHandler.
REQ-005 Port: response  input  8  byte to queue, valid when response_ready=1.
REQ-006 Port: tx_busy  input  1  UART_TX currently shifting a frame.
REQ-007 Port: tx_done  input  1  one-cycle pulse from UART_TX at frame end.
REQ-008 Port: tx_start  output  1  one-cycle request to UART_TX to send tx_data.
REQ-009 Port: tx_data  output  8  byte handed to UART_TX; stable from tx_start until tx_done.
REQ-010 Port: queue_count  output  $clog2(DEPTH)+1  entries currently held.
REQ-011 Port: queue_empty  output  1  queue_count==0.
REQ-012 Port: overflow  output  1  sticky flag: at least one byte dropped since reset.

Function
REQ-013 Storage SHALL be a circular FIFO; pointers wrap modulo DEPTH; byte order out SHALL equal order in.
REQ-014 Push: response_ready=1 and (count<DEPTH or a pop occurs in the same cycle) SHALL write response at the tail.
REQ-015 Push when full with no same-cycle pop SHALL drop the byte, leave FIFO contents unchanged, set overflow=1.
REQ-016 FSM states: IDLE, START, WAIT_DONE.
REQ-017 IDLE -> START when queue non-empty and tx_busy=0; that edge SHALL pop the head into tx_data.
REQ-018 START: tx_start=1 for exactly this one cycle; SHALL advance unconditionally to WAIT_DONE.
REQ-019 WAIT_DONE -> IDLE on tx_done=1; otherwise stay; tx_start=0.
REQ-020 Latency: push into empty queue with FSM IDLE and tx_busy=0 SHALL give tx_start=1 in the second cycle after the push cycle.
REQ-021 Back-to-back: after tx_done, next tx_start SHALL occur no earlier than 2 cycles later (IDLE, then START).
REQ-022 Simultaneous push and pop SHALL leave queue_count unchanged, including at full and at count=1.
REQ-023 queue_count SHALL never exceed DEPTH nor underflow; no pop SHALL occur when empty.
REQ-024 tx_done received outside WAIT_DONE SHALL be ignored.
REQ-025 tx_busy=1 in IDLE SHALL hold the FSM in IDLE with the queue untouched.

Reset
REQ-026 reset=0 at a rising edge SHALL set: FSM=IDLE, pointers=0, queue_count=0, queue_empty=1, overflow=0, tx_start=0, tx_data=8'h00.
REQ-027 Reset mid-transmission SHALL discard all queued bytes and abandon WAIT_DONE; a later tx_done SHALL be ignored.
REQ-028 Pushes during a reset cycle SHALL be ignored; FIFO RAM contents need not be cleared.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding (2-bit enum) and the DEPTH default constant.
REQ-030 FIFO storage and pointers SHALL be a sub-module byte_fifo (push, pop, din, dout, count, full, empty); the FSM and overflow flag remain in response_tx_queue.

Verification
REQ-031 Single byte: push 8'hA5 into idle empty queue -> tx_start 2 cycles later, tx_data=8'hA5; tx_done -> IDLE, queue_empty=1.
REQ-032 Pair order: push 8'h01 then 8'h3C on consecutive cycles (code, data) -> two frames sent 8'h01 then 8'h3C, overflow=0.
REQ-033 Overflow: tx_busy=1, push 6 bytes 8'h10..8'h15 with DEPTH=4 -> count=4, overflow=1; release -> 8'h10..8'h13 sent, 8'h14/8'h15 lost.
REQ-034 Full with pop: full queue, push 8'hEE in pop cycle -> count stays 4, overflow=0, 8'hEE sent last.
REQ-035 Reset mid-frame: 3 bytes queued, reset in WAIT_DONE -> count=0, tx_start=0; stray tx_done ignored; next push 8'h77 sent normally.
REQ-036 Pointer wrap: stream 10 bytes 8'h00..8'h09 with tx_done 3 cycles after each tx_start -> all 10 delivered in order, overflow=0.
